// File: rtl/seg_scan_capture.sv
// seg_scan_capture: passive reader for a time-multiplexed seven-segment bus.
// Samples the active-low anode/cathode/DP lines, waits for STABLE_CYC equal
// samples, then decodes the selected digit into a per-digit nibble, DP and
// valid flag. Raises frame_o once every digit has been seen, err_o on bad
// anode/segment patterns, and stale_o when captures stop arriving.
// Optional: define SEG_SCAN_DP_CAPTURE_EN to track and report the decimal
// point; otherwise dp_in is ignored and dp_o stays 0.
module seg_scan_capture #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an_in,
  input  logic [6:0]            hex_in,
  input  logic                  dp_in,
  output logic [4*DIGITS-1:0]   digit_o,
  output logic [DIGITS-1:0]     dp_o,
  output logic [DIGITS-1:0]     dval_o,
  output logic                  frame_o,
  output logic                  err_o,
  output logic                  stale_o
);

  // Sample layout: {anodes, cathodes[6:0], dp}
  localparam int unsigned SW      = DIGITS + 8;
  localparam int unsigned TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [7:0]  CNT_CAP = 8'(STABLE_CYC - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HELD    = 2'd3;

  logic [SW-1:0]     s_in;
  logic [SW-1:0]     s_q;
  logic [SW-1:0]     cap_q;
  logic [7:0]        cnt_q;
  logic [1:0]        state_q;
  logic [1:0]        state_nx;
  logic [TW-1:0]     tcnt_q;
  logic [DIGITS-1:0] seen_q;
  logic [DIGITS-1:0] seen_nx;
  logic              dp_bit;
  logic              s_idle;

  logic [DIGITS-1:0] cap_sel;
  logic [6:0]        cap_hex;
  logic              one_hot;
  logic [4:0]        glyph;
  logic              glyph_ok;
  logic              glyph_blank;
  logic              cap_one;
  logic              cap_many;

`ifdef SEG_SCAN_DP_CAPTURE_EN
  assign dp_bit = dp_in;
`else
  // DP held constant so it never disturbs the stability comparison
  logic unused_dp;
  assign unused_dp = dp_in;
  assign dp_bit    = 1'b1;
`endif

  assign s_in   = {an_in, hex_in, dp_bit};
  assign s_idle = &s_q[SW-1:8];

  // {legal, nibble} for an active-low cathode pattern
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'h40:   return {1'b1, 4'h0};
      7'h79:   return {1'b1, 4'h1};
      7'h24:   return {1'b1, 4'h2};
      7'h30:   return {1'b1, 4'h3};
      7'h19:   return {1'b1, 4'h4};
      7'h12:   return {1'b1, 4'h5};
      7'h02:   return {1'b1, 4'h6};
      7'h78:   return {1'b1, 4'h7};
      7'h00:   return {1'b1, 4'h8};
      7'h10:   return {1'b1, 4'h9};
      7'h08:   return {1'b1, 4'hA};
      7'h03:   return {1'b1, 4'hB};
      7'h46:   return {1'b1, 4'hC};
      7'h21:   return {1'b1, 4'hD};
      7'h06:   return {1'b1, 4'hE};
      7'h0E:   return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

  // Sample register and saturating run-length of identical samples
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '1;
      cnt_q <= '0;
    end else begin
      s_q <= s_in;
      if (s_in != s_q)
        cnt_q <= '0;
      else if (cnt_q != '1)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  // Next-state logic: settle on a stable non-idle sample, capture once, hold
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!s_idle)
          state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (s_idle)
          state_nx = ST_IDLE;
        else if (cnt_q >= CNT_CAP)
          state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_nx = ST_HELD;
      end
      default: begin
        if (s_q != cap_q)
          state_nx = s_idle ? ST_IDLE : ST_SETTLE;
      end
    endcase
  end

  // State register; the settled sample is frozen for the capture cycle and
  // doubles as the reference for leaving HELD
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cap_q   <= '1;
    end else begin
      state_q <= state_nx;
      if (state_q == ST_SETTLE && state_nx == ST_CAPTURE)
        cap_q <= s_q;
    end
  end

  // Decode of the frozen sample
  always_comb begin
    cap_sel     = ~cap_q[SW-1:8];
    cap_hex     = cap_q[7:1];
    one_hot     = (cap_sel != '0) && ((cap_sel & (cap_sel - DIGITS'(1))) == '0);
    glyph       = decode_glyph(cap_hex);
    glyph_ok    = glyph[4];
    glyph_blank = (cap_hex == 7'h7F);
    cap_one     = (state_q == ST_CAPTURE) && one_hot;
    cap_many    = (state_q == ST_CAPTURE) && !one_hot;
    seen_nx     = seen_q | cap_sel;
  end

  // Capture write-back, frame tracking and inactivity timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_o <= '0;
      dval_o  <= '0;
      frame_o <= 1'b0;
      err_o   <= 1'b0;
      stale_o <= 1'b0;
      seen_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      frame_o <= 1'b0;
      err_o   <= 1'b0;
      if (cap_one) begin
        tcnt_q  <= '0;
        stale_o <= 1'b0;
        if (&seen_nx) begin
          seen_q  <= '0;
          frame_o <= 1'b1;
        end else begin
          seen_q <= seen_nx;
        end
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (cap_sel[i]) begin
            dval_o[i] <= glyph_ok;
            if (glyph_ok)
              digit_o[4*i +: 4] <= glyph[3:0];
          end
        end
        if (!glyph_ok && !glyph_blank)
          err_o <= 1'b1;
      end else begin
        if (cap_many)
          err_o <= 1'b1;
        if (tcnt_q != TO_LAST) begin
          tcnt_q <= tcnt_q + TW'(1);
          if (tcnt_q + TW'(1) == TO_LAST) begin
            stale_o <= 1'b1;
            dval_o  <= '0;
            seen_q  <= '0;
          end
        end
      end
    end
  end

`ifdef SEG_SCAN_DP_CAPTURE_EN
  // Per-digit decimal point, updated only alongside a legal glyph
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_o <= '0;
    end else if (cap_one && glyph_ok) begin
      for (int unsigned i = 0; i < DIGITS; i++)
        if (cap_sel[i])
          dp_o[i] <= ~cap_q[0];
    end
  end
`else
  assign dp_o = '0;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: default-timeout instance for the main
// decode paths and a TIMEOUT_CYC=32 instance for the stale flag.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an_in;
  logic [6:0]  hex_in;
  logic        dp_in;

  logic [31:0] digit_o, digit_t;
  logic [7:0]  dp_o, dp_t, dval_o, dval_t;
  logic        frame_o, err_o, stale_o;
  logic        frame_t, err_t, stale_t;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int frame_cnt = 0;

`ifdef SEG_SCAN_DP_CAPTURE_EN
  localparam logic DP_EXP = 1'b1;
`else
  localparam logic DP_EXP = 1'b0;
`endif

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg_scan_capture u_dut (
    .clk(clk), .rst(rst), .an_in(an_in), .hex_in(hex_in), .dp_in(dp_in),
    .digit_o(digit_o), .dp_o(dp_o), .dval_o(dval_o),
    .frame_o(frame_o), .err_o(err_o), .stale_o(stale_o)
  );

  seg_scan_capture #(.TIMEOUT_CYC(32)) u_to (
    .clk(clk), .rst(rst), .an_in(an_in), .hex_in(hex_in), .dp_in(dp_in),
    .digit_o(digit_t), .dp_o(dp_t), .dval_o(dval_t),
    .frame_o(frame_t), .err_o(err_t), .stale_o(stale_t)
  );

  // Pulse counters, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (err_o)   err_cnt++;
    if (frame_o) frame_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: drive the bus and hold it for n cycles
  task automatic apply(input logic [7:0] an, input logic [6:0] hx, input logic dp, input int n);
    an_in = an; hex_in = hx; dp_in = dp;
    cycles(n);
  endtask

  task automatic test_reset();
    rst = 1'b1; an_in = 8'hFF; hex_in = 7'h7F; dp_in = 1'b1;
    cycles(3);
    checks++; if (digit_o !== 32'h0) begin errors++; $display("FAIL reset_digit got %h want %h", digit_o, 32'h0); end
    checks++; if (dval_o !== 8'h00) begin errors++; $display("FAIL reset_dval got %h want %h", dval_o, 8'h00); end
    checks++; if (dp_o !== 8'h00) begin errors++; $display("FAIL reset_dp got %h want %h", dp_o, 8'h00); end
    checks++; if ({frame_o, err_o, stale_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want %b", {frame_o, err_o, stale_o}, 3'b000); end
    checks++; if (stale_t !== 1'b0) begin errors++; $display("FAIL reset_stale_t got %b want %b", stale_t, 1'b0); end
  endtask

  task automatic test_single();
    int e0;
    e0 = err_cnt;
    rst = 1'b0;
    apply(8'hFE, 7'h40, 1'b1, 5);
    checks++; if (dval_o[0] !== 1'b0) begin errors++; $display("FAIL single_early got %b want %b", dval_o[0], 1'b0); end
    cycles(1);
    checks++; if (dval_o[0] !== 1'b1) begin errors++; $display("FAIL single_dval got %b want %b", dval_o[0], 1'b1); end
    checks++; if (digit_o[3:0] !== 4'h0) begin errors++; $display("FAIL single_digit got %h want %h", digit_o[3:0], 4'h0); end
    checks++; if (dp_o[0] !== 1'b0) begin errors++; $display("FAIL single_dp got %b want %b", dp_o[0], 1'b0); end
    cycles(4);
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL single_err got %0d want %0d", err_cnt - e0, 0); end
  endtask

  task automatic test_frame();
    int f0;
    f0 = frame_cnt;
    for (int d = 0; d < 8; d++) begin
      apply(8'(~(8'h01 << d)), glyph[d+1], (d == 2) ? 1'b0 : 1'b1, 6);
      if (d == 6) begin
        checks++; if (frame_cnt !== f0) begin errors++; $display("FAIL frame_early got %0d want %0d", frame_cnt - f0, 0); end
      end
      if (d == 7) begin
        checks++; if (frame_o !== 1'b1) begin errors++; $display("FAIL frame_coincide got %b want %b", frame_o, 1'b1); end
      end
    end
    checks++; if (digit_o !== 32'h87654321) begin errors++; $display("FAIL frame_digits got %h want %h", digit_o, 32'h87654321); end
    checks++; if (dval_o !== 8'hFF) begin errors++; $display("FAIL frame_dval got %h want %h", dval_o, 8'hFF); end
    checks++; if (dp_o !== {5'b0, DP_EXP, 2'b0}) begin errors++; $display("FAIL frame_dp got %h want %h", dp_o, {5'b0, DP_EXP, 2'b0}); end
    checks++; if (frame_cnt !== f0 + 1) begin errors++; $display("FAIL frame_count got %0d want %0d", frame_cnt - f0, 1); end
  endtask

  task automatic test_multi_anode();
    int e0, f0;
    e0 = err_cnt; f0 = frame_cnt;
    apply(8'hFC, 7'h40, 1'b1, 8);
    checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL multi_err got %0d want %0d", err_cnt - e0, 1); end
    checks++; if (digit_o !== 32'h87654321) begin errors++; $display("FAIL multi_digits got %h want %h", digit_o, 32'h87654321); end
    checks++; if (dval_o !== 8'hFF) begin errors++; $display("FAIL multi_dval got %h want %h", dval_o, 8'hFF); end
    checks++; if (frame_cnt !== f0) begin errors++; $display("FAIL multi_frame got %0d want %0d", frame_cnt - f0, 0); end
  endtask

  task automatic test_unstable();
    int e0;
    e0 = err_cnt;
    for (int k = 0; k < 5; k++)
      apply(8'hFD, (k % 2 == 1) ? 7'h79 : 7'h40, 1'b1, 2);
    checks++; if (digit_o[7:4] !== 4'h2) begin errors++; $display("FAIL unstable_hold got %h want %h", digit_o[7:4], 4'h2); end
    apply(8'hFD, 7'h79, 1'b1, 8);
    checks++; if (digit_o[7:4] !== 4'h1) begin errors++; $display("FAIL unstable_capture got %h want %h", digit_o[7:4], 4'h1); end
    checks++; if (dval_o[1] !== 1'b1) begin errors++; $display("FAIL unstable_dval got %b want %b", dval_o[1], 1'b1); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL unstable_err got %0d want %0d", err_cnt - e0, 0); end
  endtask

  task automatic test_blank_illegal();
    int e0, f0;
    e0 = err_cnt; f0 = frame_cnt;
    apply(8'hF7, 7'h7F, 1'b1, 8);
    checks++; if (dval_o !== 8'hF7) begin errors++; $display("FAIL blank_dval got %h want %h", dval_o, 8'hF7); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL blank_err got %0d want %0d", err_cnt - e0, 0); end
    checks++; if (digit_o[15:12] !== 4'h4) begin errors++; $display("FAIL blank_digit got %h want %h", digit_o[15:12], 4'h4); end
    apply(8'hF7, 7'h2B, 1'b1, 8);
    checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL illegal_err got %0d want %0d", err_cnt - e0, 1); end
    checks++; if (dval_o !== 8'hF7) begin errors++; $display("FAIL illegal_dval got %h want %h", dval_o, 8'hF7); end
    checks++; if (digit_o[15:12] !== 4'h4) begin errors++; $display("FAIL illegal_digit got %h want %h", digit_o[15:12], 4'h4); end
    checks++; if (frame_cnt !== f0) begin errors++; $display("FAIL illegal_frame got %0d want %0d", frame_cnt - f0, 0); end
  endtask

  task automatic test_reset_midsettle();
    apply(8'hFE, 7'h79, 1'b1, 3);
    rst = 1'b1;
    cycles(1);
    checks++; if (dval_o !== 8'h00) begin errors++; $display("FAIL rstmid_dval got %h want %h", dval_o, 8'h00); end
    checks++; if (digit_o !== 32'h0) begin errors++; $display("FAIL rstmid_digit got %h want %h", digit_o, 32'h0); end
    rst = 1'b0;
    cycles(5);
    checks++; if (dval_o[0] !== 1'b0) begin errors++; $display("FAIL rstmid_early got %b want %b", dval_o[0], 1'b0); end
    cycles(1);
    checks++; if (dval_o[0] !== 1'b1) begin errors++; $display("FAIL rstmid_dval0 got %b want %b", dval_o[0], 1'b1); end
    checks++; if (digit_o[3:0] !== 4'h1) begin errors++; $display("FAIL rstmid_digit0 got %h want %h", digit_o[3:0], 4'h1); end
  endtask

  task automatic test_timeout();
    for (int d = 0; d < 8; d++)
      apply(8'(~(8'h01 << d)), glyph[d], 1'b1, 6);
    checks++; if (dval_t !== 8'hFF) begin errors++; $display("FAIL to_frame_dval got %h want %h", dval_t, 8'hFF); end
    apply(8'hFF, 7'h7F, 1'b1, 30);
    checks++; if (stale_t !== 1'b0) begin errors++; $display("FAIL to_early got %b want %b", stale_t, 1'b0); end
    cycles(1);
    checks++; if (stale_t !== 1'b1) begin errors++; $display("FAIL to_stale got %b want %b", stale_t, 1'b1); end
    checks++; if (dval_t !== 8'h00) begin errors++; $display("FAIL to_dval got %h want %h", dval_t, 8'h00); end
    checks++; if (stale_o !== 1'b0) begin errors++; $display("FAIL to_main_stale got %b want %b", stale_o, 1'b0); end
    cycles(9);
    checks++; if (stale_t !== 1'b1) begin errors++; $display("FAIL to_hold got %b want %b", stale_t, 1'b1); end
    apply(8'hFE, 7'h79, 1'b1, 6);
    checks++; if (stale_t !== 1'b0) begin errors++; $display("FAIL to_clear got %b want %b", stale_t, 1'b0); end
    checks++; if (dval_t !== 8'h01) begin errors++; $display("FAIL to_recap_dval got %h want %h", dval_t, 8'h01); end
    checks++; if (digit_t[3:0] !== 4'h1) begin errors++; $display("FAIL to_recap_digit got %h want %h", digit_t[3:0], 4'h1); end
  endtask

  initial begin
    rst = 1'b1; an_in = 8'hFF; hex_in = 7'h7F; dp_in = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_frame();
    test_multi_anode();
    test_unstable();
    test_blank_illegal();
    test_reset_midsettle();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
